// File: rtl/qft_stream_pkg.sv
// qft_stream_pkg: shared constants and helpers for the streaming QFT core.
//   - FSM state encodings (StLoad / StCompute / StUnload)
//   - k_const:    1/sqrt2 in FRAC_W fraction bits
//   - twiddle:    K-prescaled cos/sin of exp(+/-2*pi*i*e/N)
//   - bitrev:     NQ-bit index reversal (up to 4 bits)
//   - round_sat:  round-half-up, arithmetic shift by FRAC_W, clip to DATA_W
package qft_stream_pkg;

    localparam logic [1:0] StLoad    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StUnload  = 2'd2;

    typedef logic signed [15:0] coef_t;

    typedef struct packed {
        coef_t c;
        coef_t s;
    } twiddle_t;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] v;
    } rsat_t;

    // K*sin(q*pi/8) for q = 0..4 as Q16; angles on a 16-point circle cover NQ <= 4.
    function automatic int unsigned ksin_q16(input int unsigned q);
        int unsigned r;
        case (q)
            32'd0:   r = 32'd0;
            32'd1:   r = 32'd17734;
            32'd2:   r = 32'd32768;
            32'd3:   r = 32'd42814;
            default: r = 32'd46341;
        endcase
        return r;
    endfunction

    // Round a non-negative Q16 value to frac_w fraction bits (frac_w in 1..15).
    function automatic coef_t q16_to_frac(input int unsigned v, input int unsigned frac_w);
        int unsigned r;
        r = (v + (32'd1 << (15 - frac_w))) >> (16 - frac_w);
        return coef_t'(r);
    endfunction

    function automatic coef_t k_const(input int unsigned frac_w);
        return q16_to_frac(32'd46341, frac_w);
    endfunction

    // e in 0..N/2-1, so the angle stays within the upper half circle (q = 0..7).
    function automatic twiddle_t twiddle(input int unsigned e, input int unsigned nq,
                                         input int unsigned frac_w, input logic inv);
        twiddle_t    t;
        int unsigned q;
        q = (e << (4 - nq)) & 32'd7;
        if (q <= 32'd4) t.c = q16_to_frac(ksin_q16(32'd4 - q), frac_w);
        else            t.c = -q16_to_frac(ksin_q16(q - 32'd4), frac_w);
        t.s = q16_to_frac(ksin_q16((q <= 32'd4) ? q : 32'd8 - q), frac_w);
        if (inv) t.s = -t.s;
        return t;
    endfunction

    function automatic logic [3:0] bitrev(input logic [3:0] k, input int unsigned nq);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (32'(i) < nq) r[2'(i)] = k[2'(nq - 32'd1 - 32'(i))];
        end
        return r;
    endfunction

    function automatic rsat_t round_sat(input logic signed [63:0] x, input int unsigned frac_w,
                                        input int unsigned data_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rsat_t              o;
        r  = (x + (64'sd1 <<< (frac_w - 32'd1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 32'd1));
        o.sat = 1'b1;
        if (r > hi)      o.v = 32'(hi);
        else if (r < lo) o.v = 32'(lo);
        else begin
            o.v   = 32'(r);
            o.sat = 1'b0;
        end
        return o;
    endfunction

endpackage

// File: rtl/qft_butterfly.sv
// qft_butterfly: combinational radix-2 DIF butterfly, outputs scaled by 1/sqrt2.
//   a, b    : input pair (signed, DATA_W, FRAC_W fraction bits)
//   tw      : twiddle already prescaled by K
//   x       : (a+b)*K
//   y       : (a-b)*W*K
//   sat     : any of the four results clipped
module qft_butterfly
    import qft_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  twiddle_t                 tw,
    output logic signed [DATA_W-1:0] x_re,
    output logic signed [DATA_W-1:0] x_im,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im,
    output logic                     sat
);

    localparam coef_t KC = k_const(FRAC_W);

    logic signed [DATA_W:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [63:0]     p_x_re, p_x_im, p_y_re, p_y_im;
    rsat_t                  r_x_re, r_x_im, r_y_re, r_y_im;

    always_comb begin
        // One extra bit so the sum/difference never wraps before scaling.
        sum_re = (DATA_W+1)'(a_re) + (DATA_W+1)'(b_re);
        sum_im = (DATA_W+1)'(a_im) + (DATA_W+1)'(b_im);
        dif_re = (DATA_W+1)'(a_re) - (DATA_W+1)'(b_re);
        dif_im = (DATA_W+1)'(a_im) - (DATA_W+1)'(b_im);

        p_x_re = 64'(sum_re) * 64'(KC);
        p_x_im = 64'(sum_im) * 64'(KC);
        p_y_re = 64'(dif_re) * 64'(tw.c) - 64'(dif_im) * 64'(tw.s);
        p_y_im = 64'(dif_re) * 64'(tw.s) + 64'(dif_im) * 64'(tw.c);

        r_x_re = round_sat(p_x_re, FRAC_W, DATA_W);
        r_x_im = round_sat(p_x_im, FRAC_W, DATA_W);
        r_y_re = round_sat(p_y_re, FRAC_W, DATA_W);
        r_y_im = round_sat(p_y_im, FRAC_W, DATA_W);

        x_re = DATA_W'(r_x_re.v);
        x_im = DATA_W'(r_x_im.v);
        y_re = DATA_W'(r_y_re.v);
        y_im = DATA_W'(r_y_im.v);
        sat  = r_x_re.sat | r_x_im.sat | r_y_re.sat | r_y_im.sat;
    end

endmodule

// File: rtl/qft_stream_core.sv
// qft_stream_core: resource-shared iterative QFT over a 2^NQ-amplitude state vector.
//   Loads N amplitudes over s_* (valid/ready), runs NQ*N/2 butterflies one per cycle
//   in place, then streams results over m_* in natural order (bit-reversed reads).
//   busy      : high while computing or unloading
//   sat       : sticky clip flag for the current frame
//   frame_err : sticky, s_last disagreed with beat N-1
// Build option: define QFT_INVERSE_EN to add input 'inv' (sampled on the first beat of
// a frame) selecting conjugate twiddles, i.e. the inverse QFT.
module qft_stream_core
    import qft_stream_pkg::*;
#(
    parameter int unsigned NQ     = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef QFT_INVERSE_EN
    input  logic                     inv,
`endif
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_re,
    input  logic signed [DATA_W-1:0] s_im,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_re,
    output logic signed [DATA_W-1:0] m_im,
    output logic [NQ-1:0]            m_idx,
    output logic                     m_last,
    output logic                     busy,
    output logic                     sat,
    output logic                     frame_err
);

    localparam int unsigned   N          = 1 << NQ;
    localparam logic [NQ-1:0] LAST_IDX   = NQ'(N - 1);
    localparam logic [NQ-1:0] LAST_BFLY  = NQ'(N / 2 - 1);
    localparam logic [2:0]    LAST_STAGE = 3'(NQ - 1);

    logic [1:0]              state_q, state_d;
    logic [NQ-1:0]           idx_q;
    logic [NQ-1:0]           bfly_q;
    logic [2:0]              stage_q;
    logic                    sat_q, frame_err_q;
    logic signed [DATA_W-1:0] rf_re [N];
    logic signed [DATA_W-1:0] rf_im [N];

    logic                    s_fire, m_fire, last_mismatch;
    logic [31:0]             span, mask, bsel, pidx, expo;
    logic [NQ-1:0]           addr_a, addr_b, rd_addr;
    logic [3:0]              rd_rev;
    twiddle_t                tw;
    logic signed [DATA_W-1:0] x_re, x_im, y_re, y_im;
    logic                    bf_sat;

    assign s_ready       = (state_q == StLoad);
    assign s_fire        = s_valid & s_ready;
    assign m_valid       = (state_q == StUnload);
    assign m_fire        = m_valid & m_ready;
    assign busy          = ~s_ready;
    assign sat           = sat_q;
    assign frame_err     = frame_err_q;
    assign last_mismatch = s_last ^ (idx_q == LAST_IDX);

    // Final SWAP stage folded into read addressing.
    assign rd_rev  = bitrev(4'(idx_q), NQ);
    assign rd_addr = NQ'(rd_rev);
    assign m_re    = m_valid ? rf_re[rd_addr] : '0;
    assign m_im    = m_valid ? rf_im[rd_addr] : '0;
    assign m_idx   = m_valid ? idx_q : '0;
    assign m_last  = m_valid & (idx_q == LAST_IDX);

    // Pair (p, p+span): p keeps the low bits of b and doubles the high bits.
    always_comb begin
        bsel   = 32'(bfly_q);
        span   = N >> (32'(stage_q) + 32'd1);
        mask   = span - 32'd1;
        pidx   = ((bsel & ~mask) << 1) | (bsel & mask);
        expo   = (bsel & mask) << stage_q;
        addr_a = NQ'(pidx);
        addr_b = NQ'(pidx + span);
    end

`ifdef QFT_INVERSE_EN
    logic inv_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        inv_q <= 1'b0;
        else if (s_fire && idx_q == '0)    inv_q <= inv;
    end
    assign tw = twiddle(expo, NQ, FRAC_W, inv_q);
`else
    assign tw = twiddle(expo, NQ, FRAC_W, 1'b0);
`endif

    qft_butterfly #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_bfly (
        .a_re (rf_re[addr_a]),
        .a_im (rf_im[addr_a]),
        .b_re (rf_re[addr_b]),
        .b_im (rf_im[addr_b]),
        .tw   (tw),
        .x_re (x_re),
        .x_im (x_im),
        .y_re (y_re),
        .y_im (y_im),
        .sat  (bf_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoad:    if (s_fire && idx_q == LAST_IDX) state_d = StCompute;
            StCompute: if (bfly_q == LAST_BFLY && stage_q == LAST_STAGE) state_d = StUnload;
            StUnload:  if (m_fire && idx_q == LAST_IDX) state_d = StLoad;
            default:   state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            idx_q       <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            sat_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Shared beat counter: wraps to 0 after beat N-1 in both LOAD and UNLOAD.
            if (s_fire || m_fire) idx_q <= idx_q + NQ'(1);
            if (state_q == StCompute) begin
                if (bfly_q == LAST_BFLY) begin
                    bfly_q  <= '0;
                    stage_q <= (stage_q == LAST_STAGE) ? 3'd0 : stage_q + 3'd1;
                end else begin
                    bfly_q <= bfly_q + NQ'(1);
                end
                if (bf_sat) sat_q <= 1'b1;
            end
            if (s_fire) begin
                if (idx_q == '0) begin
                    sat_q       <= 1'b0;
                    frame_err_q <= last_mismatch;
                end else if (last_mismatch) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                rf_re[i] <= '0;
                rf_im[i] <= '0;
            end
        end else if (s_fire) begin
            rf_re[idx_q] <= s_re;
            rf_im[idx_q] <= s_im;
        end else if (state_q == StCompute) begin
            rf_re[addr_a] <= x_re;
            rf_im[addr_a] <= x_im;
            rf_re[addr_b] <= y_re;
            rf_im[addr_b] <= y_im;
        end
    end

endmodule

// File: tb/tb_qft_stream_core.sv
`timescale 1ns/1ps
module tb_qft_stream_core;

    localparam int unsigned NQ     = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FRAC_W = 4;
    localparam int          N      = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_re = '0;
    logic signed [DATA_W-1:0] s_im = '0;
    logic                     s_last = 1'b0;
    logic                     m_valid;
    logic                     m_ready = 1'b1;
    logic signed [DATA_W-1:0] m_re;
    logic signed [DATA_W-1:0] m_im;
    logic [NQ-1:0]            m_idx;
    logic                     m_last;
    logic                     busy;
    logic                     sat;
    logic                     frame_err;
`ifdef QFT_INVERSE_EN
    logic                     inv = 1'b0;
`endif

    always #5 clk = ~clk;

    qft_stream_core #(
        .NQ     (NQ),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef QFT_INVERSE_EN
        .inv       (inv),
`endif
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .busy      (busy),
        .sat       (sat),
        .frame_err (frame_err)
    );

    typedef struct {
        int re;
        int im;
        int idx;
        int tol;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   in_re[N], in_im[N], ex_re[N], ex_im[N];
    int   ex_tol;
    int   lat;

    task automatic chk(input string tag, input int obs, input int expv, input int tol);
        checks++;
        assert (obs >= expv - tol && obs <= expv + tol)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
        end
    endtask

    task automatic clear_vecs();
        for (int i = 0; i < N; i++) begin
            in_re[i] = 0; in_im[i] = 0; ex_re[i] = 0; ex_im[i] = 0;
        end
    endtask

    task automatic send_frame(input int last_pos, input bit inv_val);
        exp_t e;
        chk("s_ready_load", int'(s_ready), 1, 0);
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_re    = DATA_W'(in_re[i]);
            s_im    = DATA_W'(in_im[i]);
            s_last  = (i == last_pos);
`ifdef QFT_INVERSE_EN
            inv     = inv_val;
`endif
            e.re = ex_re[i]; e.im = ex_im[i]; e.idx = i; e.tol = ex_tol;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("s_ready_drop", int'(s_ready), 0, 0);
        chk("busy_compute", int'(busy), 1, 0);
        if (inv_val) ; // inversion is only meaningful in the QFT_INVERSE_EN build
    endtask

    task automatic wait_unload(output int cycles);
        cycles = 0;
        while (!m_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic drain(input bit rnd, input int budget);
        exp_t e;
        int   n = 0;
        int   hr = 0, hi = 0, hx = 0;
        bit   held = 1'b0;
        while (exp_q.size() > 0 && n < budget) begin
            if (held) begin
                chk("hold_valid", int'(m_valid), 1, 0);
                chk("hold_re", int'(m_re), hr, 0);
                chk("hold_im", int'(m_im), hi, 0);
                chk("hold_idx", int'(m_idx), hx, 0);
                held = 1'b0;
            end
            if (m_valid) begin
                chk("s_ready_unload", int'(s_ready), 0, 0);
                if (m_ready) begin
                    e = exp_q.pop_front();
                    chk("m_re", int'(m_re), e.re, e.tol);
                    chk("m_im", int'(m_im), e.im, e.tol);
                    chk("m_idx", int'(m_idx), e.idx, 0);
                    chk("m_last", int'(m_last), int'(e.idx == N - 1), 0);
                end else begin
                    held = 1'b1;
                    hr = int'(m_re); hi = int'(m_im); hx = int'(m_idx);
                end
            end
            @(posedge clk); #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0, 0);
        exp_q.delete();
        m_ready = 1'b1;
        chk("s_ready_rise", int'(s_ready), 1, 0);
        chk("m_valid_idle", int'(m_valid), 0, 0);
    endtask

    task automatic setup_110();
        clear_vecs();
        in_re[6] = 16;
        ex_re = '{5, 0, -5, 0, 5, 0, -5, 0};
        ex_im = '{0, -5, 0, 5, 0, -5, 0, 5};
        ex_tol = 1;
    endtask

    task automatic setup_000();
        clear_vecs();
        in_re[0] = 16;
        for (int i = 0; i < N; i++) ex_re[i] = 5;
        ex_tol = 1;
    endtask

    initial begin
        // Reset values
        #22;
        chk("rst_s_ready", int'(s_ready), 1, 0);
        chk("rst_m_valid", int'(m_valid), 0, 0);
        chk("rst_m_re", int'(m_re), 0, 0);
        chk("rst_m_im", int'(m_im), 0, 0);
        chk("rst_m_idx", int'(m_idx), 0, 0);
        chk("rst_m_last", int'(m_last), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_sat", int'(sat), 0, 0);
        chk("rst_frame_err", int'(frame_err), 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // |000> : flat spectrum, latency of NQ*N/2 cycles
        setup_000();
        send_frame(N - 1, 1'b0);
        wait_unload(lat);
        chk("latency", lat, 12, 0);
        drain(1'b0, 100);
        chk("sat_000", int'(sat), 0, 0);
        chk("ferr_000", int'(frame_err), 0, 0);

        // |110>
        setup_110();
        send_frame(N - 1, 1'b0);
        wait_unload(lat);
        chk("latency_110", lat, 12, 0);
        drain(1'b0, 100);

        // Saturation: all (127,127)
        clear_vecs();
        for (int i = 0; i < N; i++) begin
            in_re[i] = 127; in_im[i] = 127;
        end
        ex_re[0] = 127; ex_im[0] = 127; ex_tol = 1;
        send_frame(N - 1, 1'b0);
        wait_unload(lat);
        drain(1'b0, 100);
        chk("sat_set", int'(sat), 1, 0);

        // |110> with random backpressure, then back-to-back |000>
        setup_110();
        send_frame(N - 1, 1'b0);
        chk("sat_cleared", int'(sat), 0, 0);
        wait_unload(lat);
        drain(1'b1, 400);
        setup_000();
        send_frame(N - 1, 1'b0);
        wait_unload(lat);
        drain(1'b0, 100);

        // s_last on beat 5: flagged, data unaffected
        setup_110();
        send_frame(5, 1'b0);
        chk("ferr_set", int'(frame_err), 1, 0);
        wait_unload(lat);
        drain(1'b0, 100);
        chk("ferr_sticky", int'(frame_err), 1, 0);

        // Reset pulse mid-COMPUTE discards the frame
        setup_000();
        send_frame(N - 1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_m_valid", int'(m_valid), 0, 0);
        chk("midrst_s_ready", int'(s_ready), 1, 0);
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_ferr", int'(frame_err), 0, 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        setup_110();
        send_frame(N - 1, 1'b0);
        wait_unload(lat);
        drain(1'b0, 100);

`ifdef QFT_INVERSE_EN
        // Inverse of the |110> spectrum returns to index 6
        clear_vecs();
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0: in_re[i] = 6;
                1: in_im[i] = -6;
                2: in_re[i] = -6;
                default: in_im[i] = 6;
            endcase
        end
        ex_re[6] = 16; ex_tol = 2;
        send_frame(N - 1, 1'b1);
        wait_unload(lat);
        drain(1'b0, 100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
